// File: rtl/accelerator_vector_stream_loader_pkg.sv
// accelerator_vector_loader_pkg: FSM state encoding and default sizing shared by the vector stream loader.
package accelerator_vector_loader_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;
   localparam int DEF_DATA_SIZE = 64;
   localparam int DEF_CONTROL_SIZE = 64;
   localparam int DEF_DEPTH = 64;
endpackage

// File: rtl/accelerator_vector_stream_loader_if.sv
// accelerator_vector_stream_loader_if: host control, buffer write and element stream signals of the loader.
// ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN adds the checksum output.
interface accelerator_vector_stream_loader_if #(
   parameter int DATA_SIZE = accelerator_vector_loader_pkg::DEF_DATA_SIZE,
   parameter int CONTROL_SIZE = accelerator_vector_loader_pkg::DEF_CONTROL_SIZE,
   parameter int DEPTH = accelerator_vector_loader_pkg::DEF_DEPTH
);
   localparam int ADDR_SIZE = $clog2(DEPTH);
   logic start;
   logic ready;
   logic [CONTROL_SIZE-1:0] size_in;
   logic wr_enable;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [DATA_SIZE-1:0] wr_data;
   logic [DATA_SIZE-1:0] data_out;
   logic data_out_enable;
   logic data_ack;
   logic error;
`ifdef ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN
   logic [DATA_SIZE-1:0] checksum;
   modport master (input start, size_in, wr_enable, wr_addr, wr_data, data_ack,
                   output ready, data_out, data_out_enable, error, checksum);
   modport slave (output start, size_in, wr_enable, wr_addr, wr_data, data_ack,
                  input ready, data_out, data_out_enable, error, checksum);
`else
   modport master (input start, size_in, wr_enable, wr_addr, wr_data, data_ack,
                   output ready, data_out, data_out_enable, error);
   modport slave (output start, size_in, wr_enable, wr_addr, wr_data, data_ack,
                  input ready, data_out, data_out_enable, error);
`endif
endinterface

// File: rtl/accelerator_vector_stream_loader_buffer.sv
// accelerator_vector_loader_buffer: DEPTH x DATA_SIZE vector store, one synchronous write, one async read.
module accelerator_vector_loader_buffer #(
   parameter int DATA_SIZE = 64,
   parameter int DEPTH = 64,
   localparam int ADDR_SIZE = $clog2(DEPTH)
) (
   input logic clk,
   input logic we,
   input logic [ADDR_SIZE-1:0] wr_addr,
   input logic [DATA_SIZE-1:0] wr_data,
   input logic [ADDR_SIZE-1:0] rd_addr,
   output logic [DATA_SIZE-1:0] rd_data
);
   logic [DATA_SIZE-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/accelerator_vector_stream_loader.sv
// accelerator_vector_stream_loader: streams a host-filled vector one acknowledged element at a time.
// ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN adds a wrap-around sum of acknowledged elements.
module accelerator_vector_stream_loader
   import accelerator_vector_loader_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int CONTROL_SIZE = DEF_CONTROL_SIZE,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic clk,
   input logic rst,
   accelerator_vector_stream_loader_if.master bus
);
   localparam int ADDR_SIZE = $clog2(DEPTH);
   state_t state;
   logic [ADDR_SIZE-1:0] index, last, rd_addr;
   logic [DATA_SIZE-1:0] rd_data;
   logic [CONTROL_SIZE-1:0] count;
   logic over, we;
   // The buffer's read port always looks one element ahead so the next load is ready at the ack edge.
   always_comb begin
      over = bus.size_in > CONTROL_SIZE'(DEPTH);
      count = over ? CONTROL_SIZE'(DEPTH) : bus.size_in;
      rd_addr = (state == IDLE) ? '0 : index + 1'b1;
      we = bus.wr_enable && state == IDLE && 32'(bus.wr_addr) < DEPTH;
   end
   accelerator_vector_loader_buffer #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_buffer (
      .clk(clk),
      .we(we),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         index <= '0;
         last <= '0;
         bus.ready <= 1'b0;
         bus.data_out <= '0;
         bus.data_out_enable <= 1'b0;
         bus.error <= 1'b0;
`ifdef ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN
         bus.checksum <= '0;
`endif
      end else begin
         bus.ready <= 1'b0;
         bus.data_out_enable <= 1'b0;
         case (state)
            IDLE:
               if (bus.start) begin
                  bus.error <= over;
                  index <= '0;
                  last <= ADDR_SIZE'(count - 1'b1);
`ifdef ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN
                  bus.checksum <= '0;
`endif
                  if (count == '0) begin
                     state <= DONE;
                     bus.ready <= 1'b1;
                  end else begin
                     state <= ISSUE;
                     bus.data_out_enable <= 1'b1;
                     bus.data_out <= rd_data;
                  end
               end
            ISSUE: state <= WAIT_ACK;
            WAIT_ACK:
               if (bus.data_ack) begin
`ifdef ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN
                  bus.checksum <= bus.checksum + bus.data_out;
`endif
                  if (index == last) begin
                     state <= DONE;
                     bus.ready <= 1'b1;
                  end else begin
                     index <= index + 1'b1;
                     bus.data_out <= rd_data;
                     bus.data_out_enable <= 1'b1;
                     state <= ISSUE;
                  end
               end
            DONE: begin
               index <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_accelerator_vector_stream_loader.sv
// tb_accelerator_vector_stream_loader: table-driven stream vectors plus hand sequences for stalls, reset and ignored inputs.
module tb_accelerator_vector_stream_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   accelerator_vector_stream_loader_if bus ();
   accelerator_vector_stream_loader dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [63:0] size;
      int d;
      int pulses;
      int ready_cyc;
      logic err;
      logic [63:0] sum;
   } vec_t;
   vec_t vecs [8];
   logic [63:0] mem [64];
   int vec_n = 0;
   int bad = 0;
   int pulses, ready_cyc, readies, mism, cnt;
   logic err1;
   logic [63:0] hold;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_n++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic write(input logic [5:0] a, input logic [63:0] v);
      bus.wr_enable = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = v;
      tick();
      bus.wr_enable = 1'b0;
      mem[a] = v;
   endtask
   // Consumer model: acks each pulse d cycles later and checks every element against the mirror.
   task automatic run_stream(input logic [63:0] n, input int d, input logic we, input logic [5:0] wa,
                             input logic [63:0] wd, output int p, output int rc, output int rn,
                             output int mm, output logic e1);
      int cyc, ack_at;
      logic [63:0] old0;
      p = 0; rc = -1; rn = 0; mm = 0; ack_at = -1;
      old0 = mem[0];
      bus.start = 1'b1;
      bus.size_in = n;
      bus.wr_enable = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      tick();
      bus.start = 1'b0;
      bus.wr_enable = 1'b0;
      if (we) mem[wa] = wd;
      e1 = bus.error;
      cyc = 1;
      while (cyc < 400) begin
         bus.data_ack = (cyc == ack_at);
         if (bus.data_out_enable) begin
            if (p >= 64) mm++;
            else if (bus.data_out !== ((p == 0) ? old0 : mem[p])) mm++;
            p++;
            ack_at = cyc + d;
         end
         if (bus.ready) begin
            rn++;
            if (rc < 0) rc = cyc;
         end
         if (rc >= 0 && cyc > rc + 3) break;
         tick();
         cyc++;
      end
      bus.data_ack = 1'b0;
   endtask
   initial begin
      vecs[0] = '{size: 64'd4, d: 1, pulses: 4, ready_cyc: 9, err: 1'b0, sum: 64'd100};
      vecs[1] = '{size: 64'd0, d: 1, pulses: 0, ready_cyc: 1, err: 1'b0, sum: 64'd0};
      vecs[2] = '{size: 64'd70, d: 1, pulses: 64, ready_cyc: 129, err: 1'b1, sum: 64'd20800};
      vecs[3] = '{size: 64'd3, d: 3, pulses: 3, ready_cyc: 13, err: 1'b0, sum: 64'd60};
      vecs[4] = '{size: 64'd1, d: 1, pulses: 1, ready_cyc: 3, err: 1'b0, sum: 64'd10};
      vecs[5] = '{size: 64'd64, d: 2, pulses: 64, ready_cyc: 193, err: 1'b0, sum: 64'd20800};
      vecs[6] = '{size: 64'd65, d: 1, pulses: 64, ready_cyc: 129, err: 1'b1, sum: 64'd20800};
      vecs[7] = '{size: 64'd2, d: 1, pulses: 2, ready_cyc: 5, err: 1'b0, sum: 64'd30};
      rst = 1'b1;
      bus.start = 1'b0;
      bus.size_in = '0;
      bus.wr_enable = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.data_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset data_out", bus.data_out, 64'd0);
      check("reset data_out_enable", {63'd0, bus.data_out_enable}, 64'd0);
      check("reset ready", {63'd0, bus.ready}, 64'd0);
      check("reset error", {63'd0, bus.error}, 64'd0);
      for (int i = 0; i < 64; i++) write(6'(i), 64'((i + 1) * 10));
      for (int i = 0; i < 8; i++) begin
         run_stream(vecs[i].size, vecs[i].d, 1'b0, 6'd0, 64'd0, pulses, ready_cyc, readies, mism, err1);
         check($sformatf("v%0d pulses", i), 64'(pulses), 64'(vecs[i].pulses));
         check($sformatf("v%0d ready cycle", i), 64'(ready_cyc), 64'(vecs[i].ready_cyc));
         check($sformatf("v%0d ready count", i), 64'(readies), 64'd1);
         check($sformatf("v%0d data errors", i), 64'(mism), 64'd0);
         check($sformatf("v%0d error", i), {63'd0, err1}, {63'd0, vecs[i].err});
`ifdef ACCELERATOR_VECTOR_LOADER_CHECKSUM_EN
         check($sformatf("v%0d checksum", i), bus.checksum, vecs[i].sum);
`endif
         if (vecs[i].err) check($sformatf("v%0d error sticky", i), {63'd0, bus.error}, 64'd1);
      end
      // Stall: ack during ISSUE is ignored, then 20 idle ack cycles must not re-pulse or move data.
      bus.start = 1'b1;
      bus.size_in = 64'd2;
      tick();
      bus.start = 1'b0;
      check("stall first pulse", {63'd0, bus.data_out_enable}, 64'd1);
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
      cnt = 0;
      mism = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.data_out_enable) cnt++;
         if (bus.data_out !== 64'd10) mism++;
         tick();
      end
      check("stall re-pulses", 64'(cnt), 64'd0);
      check("stall data moved", 64'(mism), 64'd0);
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
      check("stall second pulse", {63'd0, bus.data_out_enable}, 64'd1);
      check("stall second data", bus.data_out, 64'd20);
      tick();
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
      check("stall ready", {63'd0, bus.ready}, 64'd1);
      tick();
      // Mid-stream reset after the second ack of an over-length request.
      bus.start = 1'b1;
      bus.size_in = 64'd70;
      tick();
      bus.start = 1'b0;
      tick();
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
      tick();
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
      check("pre-reset data", bus.data_out, 64'd30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort data_out", bus.data_out, 64'd0);
      check("abort enable", {63'd0, bus.data_out_enable}, 64'd0);
      check("abort error", {63'd0, bus.error}, 64'd0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.ready || bus.data_out_enable) cnt++;
         tick();
      end
      check("abort quiet", 64'(cnt), 64'd0);
      run_stream(64'd4, 1, 1'b0, 6'd0, 64'd0, pulses, ready_cyc, readies, mism, err1);
      check("restart pulses", 64'(pulses), 64'd4);
      check("restart data errors", 64'(mism), 64'd0);
      // START and writes during streaming are dropped.
      bus.start = 1'b1;
      bus.size_in = 64'd3;
      tick();
      cnt = 0;
      mism = 0;
      readies = 0;
      hold = 64'd0;
      for (int cyc = 1; cyc < 40 && readies == 0; cyc++) begin
         bus.data_ack = (cyc == 64'(hold));
         bus.start = 1'b1;
         bus.size_in = 64'd1;
         bus.wr_enable = 1'b1;
         bus.wr_addr = 6'(cyc % 3);
         bus.wr_data = 64'd999;
         if (bus.data_out_enable) begin
            if (bus.data_out !== mem[cnt]) mism++;
            cnt++;
            hold = 64'(cyc + 1);
         end
         if (bus.ready) begin
            readies++;
            bus.start = 1'b0;
            bus.wr_enable = 1'b0;
            bus.data_ack = 1'b0;
         end else tick();
      end
      bus.start = 1'b0;
      bus.wr_enable = 1'b0;
      bus.data_ack = 1'b0;
      check("busy pulses", 64'(cnt), 64'd3);
      check("busy data errors", 64'(mism), 64'd0);
      check("busy ready", 64'(readies), 64'd1);
      tick();
      run_stream(64'd3, 1, 1'b0, 6'd0, 64'd0, pulses, ready_cyc, readies, mism, err1);
      check("busy writes dropped", 64'(mism), 64'd0);
      check("buf0 intact", 64'(mem[0]), 64'd10);
      // Write together with START: address 1 is visible in this stream, address 0 is not.
      run_stream(64'd2, 1, 1'b1, 6'd1, 64'd777, pulses, ready_cyc, readies, mism, err1);
      check("same-edge addr1 data errors", 64'(mism), 64'd0);
      run_stream(64'd1, 1, 1'b1, 6'd0, 64'd555, pulses, ready_cyc, readies, mism, err1);
      check("same-edge addr0 old data errors", 64'(mism), 64'd0);
      run_stream(64'd1, 1, 1'b0, 6'd0, 64'd0, pulses, ready_cyc, readies, mism, err1);
      check("addr0 write committed", 64'(mism), 64'd0);
      check("addr0 mirror", mem[0], 64'd555);
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad);
      $finish;
   end
endmodule
